// File: rtl/udp_tx_sched_pkg.sv
// Shared types and defaults for the two-client UDP transmit scheduler.
package udp_tx_sched_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_START = 4'b0010,
        ST_BUSY  = 4'b0100,
        ST_GAP   = 4'b1000
    } state_t;

    localparam int unsigned IFG_DEFAULT     = 12;
    localparam int unsigned TIMEOUT_DEFAULT = 65535;
    localparam int unsigned IDX_W           = 1;
    localparam int unsigned CNT_W           = 16;

endpackage

// File: rtl/udp_tx_sched_rr.sv
// Two-way round-robin picker: favours the client not served last.
module udp_tx_sched_rr
    import udp_tx_sched_pkg::*;
(
    input  logic [1:0]       req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Pick the sole requester, or the non-last client when both request.
    always_comb begin
        valid = |req;
        if (&req) begin
            idx = ~last;
        end else begin
            idx = IDX_W'(req[1]);
        end
    end

endmodule

// File: rtl/udp_tx_sched.sv
// Round-robin scheduler between two frame sources and one UDP transmitter.
module udp_tx_sched
    import udp_tx_sched_pkg::*;
#(
    parameter int unsigned IFG_CYCLES     = IFG_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cli0_req,
    input  logic [15:0] cli0_byte_num,
    input  logic [47:0] cli0_des_mac,
    input  logic [31:0] cli0_des_ip,
    input  logic [31:0] cli0_data,
    output logic        cli0_grant,
    output logic        cli0_data_req,
    output logic        cli0_done,
    output logic        cli0_err,
    input  logic        cli1_req,
    input  logic [15:0] cli1_byte_num,
    input  logic [47:0] cli1_des_mac,
    input  logic [31:0] cli1_des_ip,
    input  logic [31:0] cli1_data,
    output logic        cli1_grant,
    output logic        cli1_data_req,
    output logic        cli1_done,
    output logic        cli1_err,
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    output logic [31:0] tx_data,
    input  logic        tx_req,
    input  logic        tx_done,
    output logic        busy,
    output logic [15:0] frame_cnt0,
    output logic [15:0] frame_cnt1
);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] sel, sel_nxt;
    logic [1:0]       grant, grant_nxt;
    logic [1:0]       done_q, done_nxt;
    logic [1:0]       err_q, err_nxt;
    logic             start_nxt;
    logic             latch_en;
    logic [CNT_W-1:0] wd_cnt;
    logic [CNT_W-1:0] gap_cnt;
    logic             rr_valid;
    logic [IDX_W-1:0] rr_idx;
    logic [15:0]      win_byte_num;
    logic [47:0]      win_des_mac;
    logic [31:0]      win_des_ip;

    udp_tx_sched_rr u_rr (
        .req   ({cli1_req, cli0_req}),
        .last  (ptr),
        .valid (rr_valid),
        .idx   (rr_idx)
    );

    // Descriptor of the arbitration winner, latched on grant.
    always_comb begin
        win_byte_num = (rr_idx == IDX_W'(1)) ? cli1_byte_num : cli0_byte_num;
        win_des_mac  = (rr_idx == IDX_W'(1)) ? cli1_des_mac  : cli0_des_mac;
        win_des_ip   = (rr_idx == IDX_W'(1)) ? cli1_des_ip   : cli0_des_ip;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        grant_nxt = grant;
        done_nxt  = '0;
        err_nxt   = '0;
        start_nxt = 1'b0;
        latch_en  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rr_valid) begin
                    ptr_nxt = rr_idx;
                    if (win_byte_num == 16'd0) begin
                        err_nxt[rr_idx] = 1'b1;
                        state_nxt       = ST_GAP;
                    end else begin
                        latch_en          = 1'b1;
                        sel_nxt           = rr_idx;
                        grant_nxt         = '0;
                        grant_nxt[rr_idx] = 1'b1;
                        start_nxt         = 1'b1;
                        state_nxt         = ST_START;
                    end
                end
            end
            ST_START: begin
                state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (tx_done) begin
                    done_nxt[sel] = 1'b1;
                    grant_nxt     = '0;
                    state_nxt     = ST_GAP;
                end else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_nxt[sel] = 1'b1;
                    grant_nxt    = '0;
                    state_nxt    = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == CNT_W'(IFG_CYCLES - 1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // Registered control outputs and descriptor latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= IDX_W'(1);
            sel         <= '0;
            grant       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            tx_start_en <= 1'b0;
            busy        <= 1'b0;
            tx_byte_num <= '0;
            des_mac     <= '0;
            des_ip      <= '0;
        end else begin
            ptr         <= ptr_nxt;
            sel         <= sel_nxt;
            grant       <= grant_nxt;
            done_q      <= done_nxt;
            err_q       <= err_nxt;
            tx_start_en <= start_nxt;
            busy        <= (state_nxt != ST_IDLE);
            if (latch_en) begin
                tx_byte_num <= win_byte_num;
                des_mac     <= win_des_mac;
                des_ip      <= win_des_ip;
            end
        end
    end

    // Watchdog, inter-frame gap and per-client frame counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt     <= '0;
            gap_cnt    <= '0;
            frame_cnt0 <= '0;
            frame_cnt1 <= '0;
        end else begin
            if (state == ST_START) begin
                wd_cnt <= '0;
            end else if (state == ST_BUSY) begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end
            if (state == ST_GAP) begin
                gap_cnt <= gap_cnt + CNT_W'(1);
            end else begin
                gap_cnt <= '0;
            end
            if (done_nxt[0]) begin
                frame_cnt0 <= frame_cnt0 + 16'd1;
            end
            if (done_nxt[1]) begin
                frame_cnt1 <= frame_cnt1 + 16'd1;
            end
        end
    end

    assign cli0_grant    = grant[0];
    assign cli1_grant    = grant[1];
    assign cli0_done     = done_q[0];
    assign cli1_done     = done_q[1];
    assign cli0_err      = err_q[0];
    assign cli1_err      = err_q[1];
    assign cli0_data_req = (state == ST_BUSY) && (sel == IDX_W'(0)) && tx_req;
    assign cli1_data_req = (state == ST_BUSY) && (sel == IDX_W'(1)) && tx_req;
    assign tx_data       = (sel == IDX_W'(1)) ? cli1_data : cli0_data;

endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed self-checking bench for udp_tx_sched (IFG 12, timeout 100).
module tb_udp_tx_sched;

    logic        clk, rst_n;
    logic        cli0_req, cli1_req;
    logic [15:0] cli0_byte_num, cli1_byte_num;
    logic [47:0] cli0_des_mac, cli1_des_mac;
    logic [31:0] cli0_des_ip, cli1_des_ip;
    logic [31:0] cli0_data, cli1_data;
    logic        cli0_grant, cli1_grant, cli0_data_req, cli1_data_req;
    logic        cli0_done, cli1_done, cli0_err, cli1_err;
    logic        tx_start_en, tx_req, tx_done, busy;
    logic [15:0] tx_byte_num, frame_cnt0, frame_cnt1;
    logic [47:0] des_mac;
    logic [31:0] des_ip, tx_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int viol     = 0;
    int start_cnt = 0, done0_cnt = 0, done1_cnt = 0, err0_cnt = 0, err1_cnt = 0;
    logic [15:0] exp_cnt0 = 16'd0, exp_cnt1 = 16'd0;

    udp_tx_sched #(.IFG_CYCLES(12), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n),
        .cli0_req(cli0_req), .cli0_byte_num(cli0_byte_num), .cli0_des_mac(cli0_des_mac),
        .cli0_des_ip(cli0_des_ip), .cli0_data(cli0_data), .cli0_grant(cli0_grant),
        .cli0_data_req(cli0_data_req), .cli0_done(cli0_done), .cli0_err(cli0_err),
        .cli1_req(cli1_req), .cli1_byte_num(cli1_byte_num), .cli1_des_mac(cli1_des_mac),
        .cli1_des_ip(cli1_des_ip), .cli1_data(cli1_data), .cli1_grant(cli1_grant),
        .cli1_data_req(cli1_data_req), .cli1_done(cli1_done), .cli1_err(cli1_err),
        .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num), .des_mac(des_mac),
        .des_ip(des_ip), .tx_data(tx_data), .tx_req(tx_req), .tx_done(tx_done),
        .busy(busy), .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transmitter data-request pattern, changed away from the active edge.
    initial begin
        tx_req = 1'b0;
        forever begin
            @(negedge clk);
            tx_req = ~tx_req;
        end
    end

    // Cycle counter, pulse counters and data_req routing monitor.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_start_en) start_cnt <= start_cnt + 1;
        if (cli0_done)   done0_cnt <= done0_cnt + 1;
        if (cli1_done)   done1_cnt <= done1_cnt + 1;
        if (cli0_err)    err0_cnt  <= err0_cnt + 1;
        if (cli1_err)    err1_cnt  <= err1_cnt + 1;
        if (cli0_data_req !== (cli0_grant && !tx_start_en && tx_req)) viol <= viol + 1;
        if (cli1_data_req !== (cli1_grant && !tx_start_en && tx_req)) viol <= viol + 1;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "global timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_grant(output int who, output int at_cyc);
        who = -1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (cli0_grant) begin who = 0; break; end
            if (cli1_grant) begin who = 1; break; end
        end
        at_cyc = cyc;
        if (who < 0) check_eq("grant_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 100) begin
            tick();
            k++;
        end
        if (busy) check_eq("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic finish_frame(input int who, input int len);
        repeat (len) tick();
        check_eq("tx_data_mux", tx_data, (who == 0) ? cli0_data : cli1_data);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        if (who == 0) exp_cnt0 = exp_cnt0 + 16'd1;
        else          exp_cnt1 = exp_cnt1 + 16'd1;
        check_eq("done_pulse", (who == 0) ? cli0_done : cli1_done, 1);
        check_eq("grant_drop", cli0_grant | cli1_grant, 0);
        check_eq("frame_cnt0", frame_cnt0, exp_cnt0);
        check_eq("frame_cnt1", frame_cnt1, exp_cnt1);
    endtask

    initial begin
        int who, gcyc, mcyc, gap, k, d0, d1, e0, e1;
        rst_n = 1'b0; cli0_req = 1'b0; cli1_req = 1'b0; tx_done = 1'b0;
        cli0_byte_num = 16'd64;  cli0_des_mac = 48'h0A0B0C0D0E0F; cli0_des_ip = 32'h0A000001;
        cli1_byte_num = 16'd100; cli1_des_mac = 48'h112233445566; cli1_des_ip = 32'h0A000002;
        cli0_data = 32'hDEADBEEF; cli1_data = 32'h12345678;
        repeat (3) tick();

        // Reset values
        check_eq("rst_grant", {cli1_grant, cli0_grant}, 0);
        check_eq("rst_start", tx_start_en, 0);
        check_eq("rst_desc", {tx_byte_num, des_mac, des_ip} == 0, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cnt", {frame_cnt1, frame_cnt0}, 0);
        check_eq("rst_pulses", {cli0_done, cli1_done, cli0_err, cli1_err}, 0);
        check_eq("rst_tx_data", tx_data, 32'hDEADBEEF);
        rst_n = 1'b1;
        tick();

        // Both clients saturating: strict alternation starting with client 0
        cli0_req = 1'b1; cli1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_grant(who, gcyc);
            check_eq("rr_order", who, i % 2);
            check_eq("rr_desc_bytes", tx_byte_num, (i % 2 == 0) ? 16'd64 : 16'd100);
            if (i == 3) begin cli0_req = 1'b0; cli1_req = 1'b0; end
            finish_frame(who, 5);
        end
        check_eq("sat_cnt0", frame_cnt0, 2);
        check_eq("sat_cnt1", frame_cnt1, 2);

        // Single frame from client 0 with exact start timing
        wait_idle();
        cli0_byte_num = 16'd18; cli0_des_mac = 48'h001122334455; cli0_des_ip = 32'hC0A8010A;
        cli0_req = 1'b1;
        tick();
        check_eq("c0_grant_n1", cli0_grant, 1);
        check_eq("c0_start_n1", tx_start_en, 1);
        check_eq("c0_bytes", tx_byte_num, 16'd18);
        check_eq("c0_mac", des_mac, 48'h001122334455);
        check_eq("c0_ip", des_ip, 32'hC0A8010A);
        check_eq("c0_grant1_low", cli1_grant, 0);
        cli0_req = 1'b0;
        tick();
        check_eq("c0_start_single", tx_start_en, 0);
        check_eq("c0_grant_hold", cli0_grant, 1);
        repeat (59) tick();
        check_eq("c0_desc_stable", {tx_byte_num, des_mac, des_ip}, {16'd18, 48'h001122334455, 32'hC0A8010A});
        mcyc = cyc;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        exp_cnt0 = exp_cnt0 + 16'd1;
        check_eq("c0_done", cli0_done, 1);
        check_eq("c0_grant_drop", cli0_grant, 0);
        check_eq("c0_cnt", frame_cnt0, exp_cnt0);
        cli0_req = 1'b1;
        wait_grant(who, gcyc);
        check_eq("ifg_spacing_ok", ((gcyc - mcyc) >= 13) && ((gcyc - mcyc) <= 14), 1);
        cli0_req = 1'b0;
        finish_frame(0, 3);

        // Client 1 with zero length wins, is rejected, then client 0 is served
        wait_idle();
        cli1_byte_num = 16'd0;
        cli0_req = 1'b1; cli1_req = 1'b1;
        tick();
        check_eq("z_err1", cli1_err, 1);
        check_eq("z_err0", cli0_err, 0);
        check_eq("z_no_start", tx_start_en, 0);
        check_eq("z_no_grant", {cli1_grant, cli0_grant}, 0);
        gap = 0;
        while (busy && gap < 40) begin
            gap++;
            tick();
        end
        check_eq("z_gap_len", gap, 12);
        wait_grant(who, gcyc);
        check_eq("z_next_c0", who, 0);
        cli0_req = 1'b0; cli1_req = 1'b0; cli1_byte_num = 16'd100;
        finish_frame(0, 3);

        // Watchdog abort when tx_done never comes
        wait_idle();
        cli0_req = 1'b1;
        wait_grant(who, gcyc);
        cli0_req = 1'b0;
        k = 0;
        while (!cli0_err && k < 300) begin
            tick();
            k++;
        end
        check_eq("wd_latency", k, 101);
        check_eq("wd_grant_drop", cli0_grant, 0);
        check_eq("wd_cnt_hold", frame_cnt0, exp_cnt0);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check_eq("gap_done_ignored", {cli0_done, cli1_done}, 0);
        cli1_req = 1'b1;
        wait_grant(who, gcyc);
        check_eq("wd_next_c1", who, 1);
        cli1_req = 1'b0;
        finish_frame(1, 3);

        // Asynchronous reset in the middle of a frame
        wait_idle();
        cli0_req = 1'b1;
        wait_grant(who, gcyc);
        cli0_req = 1'b0;
        repeat (3) tick();
        d0 = done0_cnt; d1 = done1_cnt; e0 = err0_cnt; e1 = err1_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_grant", {cli1_grant, cli0_grant}, 0);
        check_eq("ar_busy", busy, 0);
        check_eq("ar_desc", {tx_byte_num, des_mac, des_ip} == 0, 1);
        check_eq("ar_cnt", {frame_cnt1, frame_cnt0}, 0);
        check_eq("ar_data_req", {cli1_data_req, cli0_data_req}, 0);
        exp_cnt0 = 16'd0; exp_cnt1 = 16'd0;
        repeat (2) tick();
        check_eq("ar_no_pulse", {done0_cnt - d0, done1_cnt - d1, err0_cnt - e0, err1_cnt - e1} == 0, 1);
        rst_n = 1'b1;
        cli0_req = 1'b1; cli1_req = 1'b1;
        tick();
        check_eq("ar_c0_first", cli0_grant, 1);
        check_eq("ar_c0_start", tx_start_en, 1);
        check_eq("ar_c1_low", cli1_grant, 0);
        cli0_req = 1'b0; cli1_req = 1'b0;
        finish_frame(0, 3);

        // Frame counter wrap
        wait_idle();
        force dut.frame_cnt0 = 16'hFFFF;
        tick();
        release dut.frame_cnt0;
        exp_cnt0 = 16'hFFFF;
        check_eq("wrap_preset", frame_cnt0, 16'hFFFF);
        cli0_req = 1'b1;
        wait_grant(who, gcyc);
        cli0_req = 1'b0;
        finish_frame(0, 3);
        check_eq("wrap_zero", frame_cnt0, 16'h0000);

        repeat (2) tick();
        check_eq("data_req_routing", viol, 0);
        check_eq("start_pulses", start_cnt, 12);
        check_eq("done0_pulses", done0_cnt, 7);
        check_eq("done1_pulses", done1_cnt, 3);
        check_eq("err0_pulses", err0_cnt, 1);
        check_eq("err1_pulses", err1_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
